// File: rtl/hex_disp_pkg.sv
// ---------------------------------------------------------------------------
// hex_disp_pkg
// Shared types and helpers for the seven-segment paging controller.
//   seg7_t       : 7-bit active-low segment vector, bit0 = a .. bit6 = g
//   SEG_BLANK    : all segments off
//   mode_e       : page-rotation mode (MANUAL or AUTO)
//   seg7_decode  : nibble -> active-low segment pattern for 0..F
// ---------------------------------------------------------------------------
package hex_disp_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } mode_e;

  // Active-low patterns, so a lit segment is a 0 bit.
  function automatic seg7_t seg7_decode(input logic [3:0] nibble);
    seg7_t seg;
    case (nibble)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_page_ctrl_if.sv
// ---------------------------------------------------------------------------
// hex_page_ctrl_if
// Bundles the debug word, the board switches/key and the display outputs.
//   hex_value   : 32-bit debug word from the master core
//   key_next_n  : raw pushbutton, active-low, asynchronous
//   auto_en     : raw switch, 1 = auto-rotate pages
//   hold        : raw switch, 1 = freeze the snapshot
//   hex0..hex3  : active-low segment drive for the four digits
//   page        : 0 = low halfword shown, 1 = high halfword shown
// Modports:
//   master : the side that supplies the word/switches and watches the digits
//   slave  : the paging controller itself
// ---------------------------------------------------------------------------
interface hex_page_ctrl_if;
  import hex_disp_pkg::*;

  logic [31:0] hex_value;
  logic        key_next_n;
  logic        auto_en;
  logic        hold;
  seg7_t       hex0;
  seg7_t       hex1;
  seg7_t       hex2;
  seg7_t       hex3;
  logic        page;

  modport master (
    output hex_value,
    output key_next_n,
    output auto_en,
    output hold,
    input  hex0,
    input  hex1,
    input  hex2,
    input  hex3,
    input  page
  );

  modport slave (
    input  hex_value,
    input  key_next_n,
    input  auto_en,
    input  hold,
    output hex0,
    output hex1,
    output hex2,
    output hex3,
    output page
  );

endinterface

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Synchronises an active-low pushbutton, filters contact bounce and emits a
// single-cycle pulse when the filtered level goes from released to pressed.
//   clk    : core clock
//   rst    : synchronous reset, active-high
//   key_n  : raw pushbutton, active-low, asynchronous to clk
//   press  : one-cycle pulse on an accepted press
// Parameters:
//   DEBOUNCE_CYCLES : consecutive differing cycles needed before a new key
//                     level is accepted (must be >= 2)
// ---------------------------------------------------------------------------
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_250_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_meta;
  logic             key_sync;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser followed by the bounce filter. The counter only
  // advances while the synced level disagrees with the accepted level, so any
  // disagreement shorter than DEBOUNCE_CYCLES is forgotten once it ends.
  // Reset values assume the key is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
      stable   <= 1'b1;
      cnt      <= '0;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
      if (key_sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= key_sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // The pulse is raised in the very cycle the filter accepts a 1->0 change,
  // so downstream logic acts on the same edge that updates the stable level.
  // It depends on registers only, so it is glitch-free inside this domain.
  assign press = stable & ~key_sync & (cnt == CNT_LAST);

endmodule

// File: rtl/hex_page_ctrl.sv
// ---------------------------------------------------------------------------
// hex_page_ctrl
// Shows a 32-bit debug word on four seven-segment digits by paging between
// its low and high halfwords. Paging is driven by a debounced key press or,
// in AUTO mode, by a free-running timer. The word is sampled into a snapshot
// at a fixed refresh rate so the digits stay readable; a hold switch freezes
// that snapshot.
//   external_clk : core clock (125 MHz on the board)
//   rst          : synchronous reset, active-high
//   bus          : hex_page_ctrl_if.slave (debug word, key, switches, digits,
//                  page indicator)
// Parameters (all must be >= 2):
//   DEBOUNCE_CYCLES : key filter length
//   AUTO_CYCLES     : cycles between automatic page toggles
//   REFRESH_CYCLES  : cycles between snapshot loads
// ---------------------------------------------------------------------------
module hex_page_ctrl
  import hex_disp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_250_000,
  parameter int AUTO_CYCLES     = 125_000_000,
  parameter int REFRESH_CYCLES  = 12_500_000
) (
  input  logic           external_clk,
  input  logic           rst,
  hex_page_ctrl_if.slave bus
);

  localparam int AUTO_W    = $clog2(AUTO_CYCLES);
  localparam int REFRESH_W = $clog2(REFRESH_CYCLES);

  localparam logic [AUTO_W-1:0]    AUTO_LAST    = AUTO_W'(AUTO_CYCLES - 1);
  localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_CYCLES - 1);

  logic                 auto_meta;
  logic                 auto_sync;
  logic                 hold_meta;
  logic                 hold_sync;

  logic                 press;
  logic                 tick;
  mode_e                mode_q;
  mode_e                mode_d;
  logic [AUTO_W-1:0]    auto_cnt;
  logic                 page_q;

  logic [REFRESH_W-1:0] refresh_cnt;
  logic [31:0]          snap;
  logic [15:0]          half;

  seg7_t                hex0_q;
  seg7_t                hex1_q;
  seg7_t                hex2_q;
  seg7_t                hex3_q;

  // Key synchronisation, filtering and press detection live in their own
  // block so the filter length can be tuned independently.
  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk   (external_clk),
    .rst   (rst),
    .key_n (bus.key_next_n),
    .press (press)
  );

  // The two slide switches only need metastability protection; they are
  // mechanical levels that nobody expects to react faster than a few cycles.
  always_ff @(posedge external_clk) begin
    if (rst) begin
      auto_meta <= 1'b0;
      auto_sync <= 1'b0;
      hold_meta <= 1'b0;
      hold_sync <= 1'b0;
    end else begin
      auto_meta <= bus.auto_en;
      auto_sync <= auto_meta;
      hold_meta <= bus.hold;
      hold_sync <= hold_meta;
    end
  end

  // Mode state register.
  always_ff @(posedge external_clk) begin
    if (rst) begin
      mode_q <= MANUAL;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Mode follows the synced switch. The timer tick is only meaningful in
  // AUTO, so it is decoded here rather than straight from the counter.
  always_comb begin
    mode_d = mode_q;
    tick   = 1'b0;
    case (mode_q)
      MANUAL: begin
        if (auto_sync) begin
          mode_d = AUTO;
        end
      end
      AUTO: begin
        tick = (auto_cnt == AUTO_LAST);
        if (!auto_sync) begin
          mode_d = MANUAL;
        end
      end
      default: begin
        mode_d = MANUAL;
      end
    endcase
  end

  // Auto-rotate timer. Holding it at zero outside AUTO gives a full period
  // after entering AUTO. A press restarts it so the user's page stays up
  // for a whole period; when a press lands on the tick cycle both agree on
  // clearing, and the page below toggles only once.
  always_ff @(posedge external_clk) begin
    if (rst) begin
      auto_cnt <= '0;
    end else if ((mode_q != AUTO) || press || tick) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + AUTO_W'(1);
    end
  end

  // Page flips once per cycle in which either source fires, even if both do.
  always_ff @(posedge external_clk) begin
    if (rst) begin
      page_q <= 1'b0;
    end else if (press || tick) begin
      page_q <= ~page_q;
    end
  end

  // Snapshot refresh. Starting the counter at its terminal value makes the
  // first load happen on the first cycle out of reset instead of a full
  // refresh period later. The counter keeps running while held so the
  // refresh cadence does not drift when hold is released.
  always_ff @(posedge external_clk) begin
    if (rst) begin
      refresh_cnt <= REFRESH_LAST;
      snap        <= '0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      if (!hold_sync) begin
        snap <= bus.hex_value;
      end
    end else begin
      refresh_cnt <= refresh_cnt + REFRESH_W'(1);
    end
  end

  assign half = page_q ? snap[31:16] : snap[15:0];

  // Registered digit drive, one cycle behind snap/page. Digits are blank
  // during reset so the board never shows a stale value.
  always_ff @(posedge external_clk) begin
    if (rst) begin
      hex0_q <= SEG_BLANK;
      hex1_q <= SEG_BLANK;
      hex2_q <= SEG_BLANK;
      hex3_q <= SEG_BLANK;
    end else begin
      hex0_q <= seg7_decode(half[3:0]);
      hex1_q <= seg7_decode(half[7:4]);
      hex2_q <= seg7_decode(half[11:8]);
      hex3_q <= seg7_decode(half[15:12]);
    end
  end

  assign bus.hex0 = hex0_q;
  assign bus.hex1 = hex1_q;
  assign bus.hex2 = hex2_q;
  assign bus.hex3 = hex3_q;
  assign bus.page = page_q;

endmodule

// File: tb/tb_hex_page_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hex_page_ctrl
// Self-checking bench for hex_page_ctrl with short timing parameters.
// A behavioural model tracks the expected digits and page from the block's
// rules (input delay queues, run lengths, modulo cycle arithmetic) and each
// scenario task compares the DUT against it and against fixed values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hex_page_ctrl;
  import hex_disp_pkg::*;

  localparam int DEB    = 4;
  localparam int AUTO_N = 16;
  localparam int REF    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  hex_page_ctrl_if bus();

  hex_page_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .AUTO_CYCLES    (AUTO_N),
    .REFRESH_CYCLES (REF)
  ) dut (
    .external_clk(clk),
    .rst         (rst),
    .bus         (bus)
  );

  int checks = 0;
  int passes = 0;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state
  bit          m_key_q[$];
  bit          m_auto_q[$];
  bit          m_hold_q[$];
  bit          m_stable;
  int          m_run;
  bit          m_auto;
  bit          m_page;
  logic [31:0] m_snap;
  logic [27:0] m_hex;
  int          m_cyc = 0;
  int          m_start = 0;
  int          m_k = 0;
  bit          m_ks, m_as, m_hs, m_press, m_tick;
  logic [15:0] m_half;

  // The model advances once per rising edge using the inputs seen at that
  // edge. m_cyc is the index of the cycle that the edge closes.
  always @(posedge clk) begin
    if (rst) begin
      m_key_q  = '{1'b1, 1'b1};
      m_auto_q = '{1'b0, 1'b0};
      m_hold_q = '{1'b0, 1'b0};
      m_stable = 1'b1;
      m_run    = 0;
      m_auto   = 1'b0;
      m_page   = 1'b0;
      m_snap   = '0;
      m_k      = 0;
      m_hex    = {4{7'h7F}};
    end else begin
      m_ks = m_key_q.pop_front();
      m_key_q.push_back(bus.key_next_n);
      m_as = m_auto_q.pop_front();
      m_auto_q.push_back(bus.auto_en);
      m_hs = m_hold_q.pop_front();
      m_hold_q.push_back(bus.hold);
      m_half = m_page ? m_snap[31:16] : m_snap[15:0];
      m_hex  = {seg_tbl[m_half[15:12]], seg_tbl[m_half[11:8]],
                seg_tbl[m_half[7:4]], seg_tbl[m_half[3:0]]};
      m_press = 1'b0;
      if (m_ks != m_stable) begin
        m_run++;
        if (m_run == DEB) begin
          m_stable = m_ks;
          m_run    = 0;
          m_press  = !m_ks;
        end
      end else begin
        m_run = 0;
      end
      m_tick = m_auto && (((m_cyc - m_start) % AUTO_N) == AUTO_N - 1);
      if (m_press || m_tick) m_page = !m_page;
      if (m_press || (!m_auto && m_as)) m_start = m_cyc + 1;
      m_auto = m_as;
      if (((m_k % REF) == 0) && !m_hs) m_snap = bus.hex_value;
      m_k++;
    end
    m_cyc++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.hex_value  = 32'h1234ABCD;
    bus.key_next_n = 1'b1;
    bus.auto_en    = 1'b0;
    bus.hold       = 1'b0;
    repeat (3) step();
    checks++;
    if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.page} !== {{4{7'h7F}}, 1'b0})
      $display("[TB] FAIL reset_blank: got %h/%b, want %h/0",
               {bus.hex3, bus.hex2, bus.hex1, bus.hex0}, bus.page, {4{7'h7F}});
    else passes++;
    rst = 1'b0;
    step();
    step();
    checks++;
    if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.page} !== {7'h08, 7'h03, 7'h46, 7'h21, 1'b0})
      $display("[TB] FAIL reset_first_load: got %h/%b, want %h/0",
               {bus.hex3, bus.hex2, bus.hex1, bus.hex0}, bus.page, {7'h08, 7'h03, 7'h46, 7'h21});
    else passes++;
    checks++;
    if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.page} !== {m_hex, m_page})
      $display("[TB] FAIL reset_model cyc %0d: got %h/%b, want %h/%b",
               m_cyc, {bus.hex3, bus.hex2, bus.hex1, bus.hex0}, bus.page, m_hex, m_page);
    else passes++;
  endtask

  task automatic test_key_press();
    bit prev;
    int toggles;
    prev = bus.page;
    toggles = 0;
    bus.key_next_n = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i == 10) bus.key_next_n = 1'b1;
      step();
      if (bus.page !== prev) toggles++;
      prev = bus.page;
      checks++;
      if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.page} !== {m_hex, m_page})
        $display("[TB] FAIL key_model cyc %0d: got %h/%b, want %h/%b",
                 m_cyc, {bus.hex3, bus.hex2, bus.hex1, bus.hex0}, bus.page, m_hex, m_page);
      else passes++;
    end
    checks++;
    if (toggles !== 1) $display("[TB] FAIL key_single_toggle: got %0d toggles, want 1", toggles);
    else passes++;
    checks++;
    if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.page} !== {7'h79, 7'h24, 7'h30, 7'h19, 1'b1})
      $display("[TB] FAIL key_high_page: got %h/%b, want %h/1",
               {bus.hex3, bus.hex2, bus.hex1, bus.hex0}, bus.page, {7'h79, 7'h24, 7'h30, 7'h19});
    else passes++;
    // short glitch must be filtered out
    toggles = 0;
    bus.key_next_n = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) bus.key_next_n = 1'b1;
      step();
      if (bus.page !== prev) toggles++;
      prev = bus.page;
      checks++;
      if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.page} !== {m_hex, m_page})
        $display("[TB] FAIL glitch_model cyc %0d: got %h/%b, want %h/%b",
                 m_cyc, {bus.hex3, bus.hex2, bus.hex1, bus.hex0}, bus.page, m_hex, m_page);
      else passes++;
    end
    checks++;
    if (toggles !== 0) $display("[TB] FAIL glitch_ignored: got %0d toggles, want 0", toggles);
    else passes++;
  endtask

  task automatic test_auto();
    bit prev;
    bit found;
    int gap;
    int t1;
    int t2;
    bus.auto_en = 1'b1;
    prev = bus.page;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (bus.page !== prev) found = 1'b1;
      prev = bus.page;
      checks++;
      if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.page} !== {m_hex, m_page})
        $display("[TB] FAIL auto_model cyc %0d: got %h/%b, want %h/%b",
                 m_cyc, {bus.hex3, bus.hex2, bus.hex1, bus.hex0}, bus.page, m_hex, m_page);
      else passes++;
    end
    checks++;
    if (!found) $display("[TB] FAIL auto_first_toggle: got none in 40 cycles, want a toggle");
    else passes++;
    gap = 0;
    found = 1'b0;
    for (int i = 1; i <= 40 && !found; i++) begin
      step();
      if (bus.page !== prev) begin
        found = 1'b1;
        gap = i;
      end
      prev = bus.page;
      checks++;
      if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.page} !== {m_hex, m_page})
        $display("[TB] FAIL auto_model cyc %0d: got %h/%b, want %h/%b",
                 m_cyc, {bus.hex3, bus.hex2, bus.hex1, bus.hex0}, bus.page, m_hex, m_page);
      else passes++;
    end
    checks++;
    if (gap !== AUTO_N) $display("[TB] FAIL auto_period: got %0d, want %0d", gap, AUTO_N);
    else passes++;
    // press lands 10 cycles after the last auto toggle
    t1 = -1;
    t2 = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) bus.key_next_n = 1'b0;
      if (i == 13) bus.key_next_n = 1'b1;
      step();
      if (bus.page !== prev) begin
        if (t1 < 0) t1 = i;
        else if (t2 < 0) t2 = i;
      end
      prev = bus.page;
      checks++;
      if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.page} !== {m_hex, m_page})
        $display("[TB] FAIL auto_press_model cyc %0d: got %h/%b, want %h/%b",
                 m_cyc, {bus.hex3, bus.hex2, bus.hex1, bus.hex0}, bus.page, m_hex, m_page);
      else passes++;
    end
    checks++;
    if (t1 !== 10) $display("[TB] FAIL auto_press_toggle: got cycle %0d, want 10", t1);
    else passes++;
    checks++;
    if (t2 !== 26) $display("[TB] FAIL auto_after_press: got cycle %0d, want 26", t2);
    else passes++;
  endtask

  task automatic test_press_at_tick();
    bit prev;
    bit found;
    int t1;
    int t2;
    int toggles;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (i >= 4 && m_auto && (((m_cyc + 5 - m_start) % AUTO_N) == AUTO_N - 1)) begin
        found = 1'b1;
      end else begin
        step();
        checks++;
        if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.page} !== {m_hex, m_page})
          $display("[TB] FAIL align_model cyc %0d: got %h/%b, want %h/%b",
                   m_cyc, {bus.hex3, bus.hex2, bus.hex1, bus.hex0}, bus.page, m_hex, m_page);
        else passes++;
      end
    end
    checks++;
    if (!found) $display("[TB] FAIL tick_align: got no aligned slot, want one within 60 cycles");
    else passes++;
    prev = bus.page;
    t1 = -1;
    t2 = -1;
    toggles = 0;
    bus.key_next_n = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      if (i == 8) bus.key_next_n = 1'b1;
      step();
      if (bus.page !== prev) begin
        toggles++;
        if (t1 < 0) t1 = i;
        else if (t2 < 0) t2 = i;
      end
      prev = bus.page;
      checks++;
      if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.page} !== {m_hex, m_page})
        $display("[TB] FAIL tick_press_model cyc %0d: got %h/%b, want %h/%b",
                 m_cyc, {bus.hex3, bus.hex2, bus.hex1, bus.hex0}, bus.page, m_hex, m_page);
      else passes++;
    end
    checks++;
    if (t1 !== 6) $display("[TB] FAIL tick_press_toggle: got cycle %0d, want 6", t1);
    else passes++;
    checks++;
    if (t2 !== 22 || toggles !== 2)
      $display("[TB] FAIL tick_press_restart: got cycle %0d (%0d toggles), want 22 (2)", t2, toggles);
    else passes++;
  endtask

  task automatic test_reset_mid_auto();
    int lat;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_page && m_auto) begin
        found = 1'b1;
      end else begin
        step();
        checks++;
        if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.page} !== {m_hex, m_page})
          $display("[TB] FAIL pre_reset_model cyc %0d: got %h/%b, want %h/%b",
                   m_cyc, {bus.hex3, bus.hex2, bus.hex1, bus.hex0}, bus.page, m_hex, m_page);
        else passes++;
      end
    end
    checks++;
    if (!found) $display("[TB] FAIL pre_reset_page: got page 0 for 40 cycles, want page 1");
    else passes++;
    rst = 1'b1;
    step();
    checks++;
    if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.page} !== {{4{7'h7F}}, 1'b0})
      $display("[TB] FAIL mid_reset_outputs: got %h/%b, want %h/0",
               {bus.hex3, bus.hex2, bus.hex1, bus.hex0}, bus.page, {4{7'h7F}});
    else passes++;
    checks++;
    if (dut.mode_q !== MANUAL) $display("[TB] FAIL mid_reset_mode: got %0d, want MANUAL", dut.mode_q);
    else passes++;
    rst = 1'b0;
    lat = -1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (lat < 0 && dut.mode_q === AUTO) lat = i;
      checks++;
      if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.page} !== {m_hex, m_page})
        $display("[TB] FAIL post_reset_model cyc %0d: got %h/%b, want %h/%b",
                 m_cyc, {bus.hex3, bus.hex2, bus.hex1, bus.hex0}, bus.page, m_hex, m_page);
      else passes++;
    end
    checks++;
    if (lat !== 3) $display("[TB] FAIL reenter_auto: got latency %0d, want 3", lat);
    else passes++;
  endtask

  task automatic test_hold();
    bit found;
    bus.auto_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.page} !== {m_hex, m_page})
        $display("[TB] FAIL hold_prep_model cyc %0d: got %h/%b, want %h/%b",
                 m_cyc, {bus.hex3, bus.hex2, bus.hex1, bus.hex0}, bus.page, m_hex, m_page);
      else passes++;
    end
    if (m_page) begin
      bus.key_next_n = 1'b0;
      for (int i = 0; i < 18; i++) begin
        if (i == 8) bus.key_next_n = 1'b1;
        step();
        checks++;
        if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.page} !== {m_hex, m_page})
          $display("[TB] FAIL hold_prep_model cyc %0d: got %h/%b, want %h/%b",
                   m_cyc, {bus.hex3, bus.hex2, bus.hex1, bus.hex0}, bus.page, m_hex, m_page);
        else passes++;
      end
    end
    bus.hold = 1'b1;
    repeat (4) step();
    bus.hex_value = 32'h0000FFFF;
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.page} !== {m_hex, m_page})
        $display("[TB] FAIL hold_model cyc %0d: got %h/%b, want %h/%b",
                 m_cyc, {bus.hex3, bus.hex2, bus.hex1, bus.hex0}, bus.page, m_hex, m_page);
      else passes++;
    end
    checks++;
    if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.page} !== {7'h08, 7'h03, 7'h46, 7'h21, 1'b0})
      $display("[TB] FAIL hold_frozen: got %h/%b, want %h/0",
               {bus.hex3, bus.hex2, bus.hex1, bus.hex0}, bus.page, {7'h08, 7'h03, 7'h46, 7'h21});
    else passes++;
    bus.hold = 1'b0;
    found = 1'b0;
    for (int i = 0; i < REF + 4 && !found; i++) begin
      step();
      if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0} === {4{7'h0E}}) found = 1'b1;
    end
    checks++;
    if (!found)
      $display("[TB] FAIL hold_release: got %h, want %h within %0d cycles",
               {bus.hex3, bus.hex2, bus.hex1, bus.hex0}, {4{7'h0E}}, REF + 4);
    else passes++;
  endtask

  task automatic test_random();
    int dur;
    for (int n = 0; n < 80; n++) begin
      bus.key_next_n = 1'($urandom_range(0, 1));
      bus.auto_en    = ($urandom_range(0, 3) != 0);
      bus.hold       = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) bus.hex_value = $urandom;
      rst = ($urandom_range(0, 24) == 0);
      dur = int'($urandom_range(1, 10));
      for (int i = 0; i < dur; i++) begin
        step();
        if (i == 0) rst = 1'b0;
        checks++;
        if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.page} !== {m_hex, m_page})
          $display("[TB] FAIL random_model cyc %0d: got %h/%b, want %h/%b",
                   m_cyc, {bus.hex3, bus.hex2, bus.hex1, bus.hex0}, bus.page, m_hex, m_page);
        else passes++;
      end
    end
    rst = 1'b0;
    bus.key_next_n = 1'b1;
    bus.hold = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.page} !== {m_hex, m_page})
        $display("[TB] FAIL random_tail_model cyc %0d: got %h/%b, want %h/%b",
                 m_cyc, {bus.hex3, bus.hex2, bus.hex1, bus.hex0}, bus.page, m_hex, m_page);
      else passes++;
    end
  endtask

  initial begin
    bus.hex_value  = 32'h1234ABCD;
    bus.key_next_n = 1'b1;
    bus.auto_en    = 1'b0;
    bus.hold       = 1'b0;
    test_reset();
    test_key_press();
    test_auto();
    test_press_at_tick();
    test_reset_mid_auto();
    test_hold();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hex_page_ctrl.md
Name: hex_page_ctrl

Overview:
- Drives the four board seven-segment digits (HEX0..HEX3) from the 32-bit debug_hex_display word produced by the master core.
- Four digits show only 16 bits, so the block pages between the low and high halfwords, either by a debounced KEY press or by an auto-rotate timer.
- Periodically snapshots the debug word so digits stay readable; a hold switch freezes the snapshot.
- Instantiated in the board top level between the master core and the HEX/LEDG pins.

Parameters:
- DEBOUNCE_CYCLES, 1_250_000: consecutive stable cycles before a key level is accepted (10 ms at 125 MHz).
- AUTO_CYCLES, 125_000_000: cycles between automatic page toggles (1 s).
- REFRESH_CYCLES, 12_500_000: cycles between snapshot loads (100 ms).
- All parameters must be >= 2. Counter widths are $clog2(param).

Ports:
- external_clk  in  1  core clock, 125 MHz
- rst  in  1  synchronous reset, active-high
- hex_value  in  32  debug word from the master core
- key_next_n  in  1  asynchronous pushbutton, active-low; a press advances the page
- auto_en  in  1  asynchronous switch; 1 selects auto-rotate
- hold  in  1  asynchronous switch; 1 freezes the snapshot
- hex0..hex3  out  7 each  segment drive, active-low, bit0=a .. bit6=g
- page  out  1  0 = low halfword shown, 1 = high halfword shown

Behaviour:
- Synchronizers: key_next_n, auto_en and hold each pass through a 2-FF synchronizer. Reset values are 1, 0, 0.
- Debounce (key only):
  - Keep a stable level, reset to 1.
  - The counter increments while the synced level differs from the stable level, and clears when they match.
  - At DEBOUNCE_CYCLES-1 the stable level takes the synced level and the counter clears.
  - press is a one-cycle pulse on a stable 1->0 transition. Release generates nothing. Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Mode FSM, states MANUAL (reset) and AUTO:
  - MANUAL -> AUTO when synced auto_en=1.
  - AUTO -> MANUAL when synced auto_en=0.
  - The auto counter clears on reset, on entering AUTO, and on every press.
  - In AUTO the counter counts 0..AUTO_CYCLES-1 and wraps. Terminal count raises a one-cycle tick.
- Page register:
  - Resets to 0.
  - Toggles on press (either state) or on tick (AUTO only).
  - If press and tick occur in the same cycle, the page toggles once and the auto counter clears.
- Snapshot:
  - snap[31:0] resets to 0. The refresh counter resets to REFRESH_CYCLES-1, so the first load happens on the first cycle after rst deasserts.
  - At terminal count the counter wraps to 0. If synced hold=0, snap <= hex_value; if hold=1, snap is unchanged.
  - The refresh counter runs regardless of mode and page.
- Display:
  - Selected halfword h = page ? snap[31:16] : snap[15:0].
  - hex0 = seg(h[3:0]), hex1 = seg(h[7:4]), hex2 = seg(h[11:8]), hex3 = seg(h[15:12]).
  - Outputs are registered: one cycle of latency from snap/page to hex*.
  - On reset, hex0..hex3 = 7'h7F (blank) and page = 0.
- Segment table, 0..F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E (hex).
- Reset mid-operation: all counters, the FSM, page, snap and the outputs return to their reset values on the next edge. No pending press survives.

Decomposition:
- Package hex_disp_pkg:
  - typedef seg7_t (logic [6:0]).
  - SEG_BLANK = 7'h7F.
  - Function seg7_decode(logic [3:0]) holding the 16-entry table above.
  - typedef enum mode_e {MANUAL, AUTO}.
- Sub-module key_debounce (synchronizer, debounce counter, press pulse), parameterised by DEBOUNCE_CYCLES.

Test Plan (DEBOUNCE_CYCLES=4, AUTO_CYCLES=16, REFRESH_CYCLES=8):
1. rst for 3 cycles with hex_value=32'h1234ABCD, then release -> within 2 cycles hex0=21, hex1=46, hex2=03, hex3=08, page=0.
2. key_next_n low for 10 cycles -> exactly one toggle, page=1, hex0=19, hex1=30, hex2=24, hex3=79. A separate 2-cycle low glitch -> no toggle.
3. auto_en=1 -> page toggles every 16 cycles. A press 10 cycles after a toggle -> immediate toggle, and the next auto toggle comes 16 cycles after the press.
4. hold=1, then hex_value=32'h0000FFFF -> display unchanged for 40 cycles. Release hold -> hex0..3=0E within REFRESH_CYCLES+4 cycles (page 0).
5. Debounced press aligned to the auto terminal-count cycle -> single page toggle and the auto counter restarts.
6. rst asserted mid-AUTO with page=1 -> next cycle hex*=7F, page=0, FSM MANUAL. With auto_en held 1 the FSM re-enters AUTO after synchronizer latency.
